jmp_sweep: RTL and testbench

JMP_SWEEP -- requirements
Module: jmp_sweep

---
 rtl/jmp_sweep.sv | 139 +++++++++++++
 tb/tb_jmp_sweep.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jmp_sweep.sv
// Triangular sweep of the cosine-LUT stride for the modulated FIR.
// jmp walks between JMP_MIN and JMP_MAX, one step per `rate` sample strobes, and stays stable for at least HOLD clocks.
module jmp_sweep #(
   parameter int LUT_DEPTH  = 512,
   parameter int JMP_MIN    = 1,
   parameter int JMP_MAX    = 32,
   parameter int RATE_WIDTH = 16,
   parameter int HOLD       = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [RATE_WIDTH-1:0]        rate,
   input  logic                         vld_i,
   output logic [$clog2(LUT_DEPTH)-1:0] jmp,
   output logic                         jmp_upd,
   output logic                         dir
);

   localparam int JW = $clog2(LUT_DEPTH);
   localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

   localparam logic [JW-1:0] JMIN    = JW'(JMP_MIN);
   localparam logic [JW-1:0] JMAX    = JW'(JMP_MAX);
   localparam logic [JW-1:0] JMIN_P1 = JW'(JMP_MIN + 1);
   localparam logic [JW-1:0] JMAX_M1 = JW'(JMP_MAX - 1);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD);
   localparam bit            SWEEPS  = (JMP_MIN != JMP_MAX);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   state_t                state;
   logic [RATE_WIDTH-1:0] cnt;
   logic                  req;
   logic                  pend;
   logic [HW-1:0]         hold;

   logic [RATE_WIDTH:0]   cnt_inc;
   logic                  hit;
   logic                  due;
   logic                  hold_ok;

   // A zero rate would never terminate the count, so it behaves like 1.
   function automatic logic [RATE_WIDTH:0] eff_rate(input logic [RATE_WIDTH-1:0] r);
      if (r == '0)
         return {{RATE_WIDTH{1'b0}}, 1'b1};
      else
         return {1'b0, r};
   endfunction

   assign cnt_inc = {1'b0, cnt} + {{RATE_WIDTH{1'b0}}, 1'b1};
   assign hit     = vld_i && (cnt_inc >= eff_rate(rate));
   assign due     = req || pend;
   // A step may land on the clock where hold counts down to 0, giving exactly HOLD stable clocks.
   assign hold_ok = (hold <= HW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         jmp     <= JMIN;
         jmp_upd <= 1'b0;
         dir     <= 1'b1;
         cnt     <= '0;
         req     <= 1'b0;
         pend    <= 1'b0;
         hold    <= '0;
      end else begin
         jmp_upd <= 1'b0;
         if (hold != '0)
            hold <= hold - HW'(1);

         case (state)
            IDLE: begin
               cnt  <= '0;
               req  <= 1'b0;
               pend <= 1'b0;
               dir  <= 1'b1;
               if (en)
                  state <= UP;
            end

            UP, DOWN: begin
               if (!en) begin
                  state <= IDLE;
                  dir   <= 1'b1;
                  cnt   <= '0;
                  req   <= 1'b0;
                  pend  <= 1'b0;
                  if (jmp != JMIN) begin
                     jmp     <= JMIN;
                     jmp_upd <= 1'b1;
                     hold    <= HOLD_LD;
                  end
               end else begin
                  if (hit) begin
                     cnt <= '0;
                     req <= 1'b1;
                  end else begin
                     if (vld_i)
                        cnt <= cnt_inc[RATE_WIDTH-1:0];
                     req <= 1'b0;
                  end

                  // Requests arriving while one is already pending collapse into it.
                  if (due && SWEEPS) begin
                     if (hold_ok) begin
                        pend    <= 1'b0;
                        jmp_upd <= 1'b1;
                        hold    <= HOLD_LD;
                        if (state == UP) begin
                           if (jmp == JMAX) begin
                              state <= DOWN;
                              dir   <= 1'b0;
                              jmp   <= JMAX_M1;
                           end else begin
                              jmp <= jmp + JW'(1);
                           end
                        end else begin
                           if (jmp == JMIN) begin
                              state <= UP;
                              dir   <= 1'b1;
                              jmp   <= JMIN_P1;
                           end else begin
                              jmp <= jmp - JW'(1);
                           end
                        end
                     end else begin
                        pend <= 1'b1;
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jmp_sweep.sv
// Directed bench for jmp_sweep: a per-clock vector table plus sequences for stepping, reflection, hold, disable and reset.
module tb_jmp_sweep;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        vld_i;
   logic [15:0] rate;
   logic [8:0]  jmp, jmp_r, jmp_f;
   logic        upd, upd_r, upd_f;
   logic        dir, dir_r, dir_f;

   int pass_cnt = 0;
   int total    = 0;
   int f_bad    = 0;

   always #5 clk = ~clk;

   jmp_sweep dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rate(rate), .vld_i(vld_i),
      .jmp(jmp), .jmp_upd(upd), .dir(dir)
   );

   jmp_sweep #(.JMP_MIN(1), .JMP_MAX(3)) dut_r (
      .clk(clk), .rst_n(rst_n), .en(en), .rate(rate), .vld_i(vld_i),
      .jmp(jmp_r), .jmp_upd(upd_r), .dir(dir_r)
   );

   jmp_sweep #(.JMP_MIN(5), .JMP_MAX(5)) dut_f (
      .clk(clk), .rst_n(rst_n), .en(en), .rate(rate), .vld_i(vld_i),
      .jmp(jmp_f), .jmp_upd(upd_f), .dir(dir_f)
   );

   // The fixed-stride instance must never move or pulse, whatever the stimulus.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (jmp_f !== 9'd5 || upd_f !== 1'b0))
         f_bad++;
   end

   typedef struct {
      logic        en;
      logic [15:0] rate;
      logic        vld;
      logic [8:0]  jmp;
      logic        upd;
      logic        dir;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cyc(input logic e, input logic [15:0] r, input logic v);
      en    = e;
      rate  = r;
      vld_i = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      vld_i = 1'b0;
      rate  = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int np, nr, k, n_upd;
      int tp[8];
      int rj[8];
      int rd[8];
      int ej[5];
      int ed[5];

      for (int i = 0; i < 8; i++) begin
         tp[i] = 0; rj[i] = 0; rd[i] = 0;
      end
      ej = '{2, 3, 2, 1, 2};
      ed = '{1, 1, 0, 0, 1};

      //              en    rate    vld   jmp   upd   dir
      tbl[0]  = '{1'b0, 16'd2, 1'b0, 9'd1, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 16'd2, 1'b0, 9'd1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 16'd2, 1'b1, 9'd1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 16'd2, 1'b1, 9'd1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 16'd2, 1'b0, 9'd2, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 16'd2, 1'b0, 9'd2, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 16'd0, 1'b1, 9'd2, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 16'd0, 1'b0, 9'd2, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 16'd0, 1'b1, 9'd2, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 16'd0, 1'b0, 9'd2, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 16'd0, 1'b0, 9'd2, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 16'd0, 1'b0, 9'd2, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 16'd0, 1'b0, 9'd3, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 16'd0, 1'b0, 9'd3, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 16'd0, 1'b0, 9'd1, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 16'd0, 1'b0, 9'd1, 1'b0, 1'b1};

      do_reset();
      check("reset_jmp", jmp, 1);
      check("reset_upd", upd, 0);
      check("reset_dir", dir, 1);

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].en, tbl[i].rate, tbl[i].vld);
         check($sformatf("tbl%0d_jmp", i), jmp, tbl[i].jmp);
         check($sformatf("tbl%0d_upd", i), upd, tbl[i].upd);
         check($sformatf("tbl%0d_dir", i), dir, tbl[i].dir);
      end

      // rate 4, one strobe every 10 clocks: step lands one clock after the 4th strobe
      do_reset();
      cyc(1'b1, 16'd4, 1'b0);
      k = 0; n_upd = 0;
      for (int c = 1; c <= 45; c++) begin
         cyc(1'b1, 16'd4, (c % 10) == 5);
         if (upd) n_upd++;
         if (k == 0 && jmp != 9'd1) k = c;
      end
      check("basic_step_cycle", k, 36);
      check("basic_upd_pulses", n_upd, 1);
      check("basic_jmp", jmp, 2);

      // strobe every clock: reflection on the 1..3 instance, hold spacing on the default one
      do_reset();
      cyc(1'b1, 16'd1, 1'b1);
      np = 0; nr = 0;
      for (int c = 1; c <= 40; c++) begin
         cyc(1'b1, 16'd1, 1'b1);
         if (upd) begin
            if (np < 8) tp[np] = c;
            np++;
         end
         if (upd_r) begin
            if (nr < 8) begin
               rj[nr] = int'(jmp_r);
               rd[nr] = int'(dir_r);
            end
            nr++;
         end
      end
      check("hold_pulses", np, 5);
      check("hold_first_step", tp[0], 2);
      for (int i = 1; i < 5; i++)
         check($sformatf("hold_interval%0d", i), tp[i] - tp[i-1], 8);
      check("refl_pulses", nr, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("refl%0d_jmp", i), rj[i], ej[i]);
         check($sformatf("refl%0d_dir", i), rd[i], ed[i]);
      end

      // disable exactly when the step from 7 to 8 would execute
      do_reset();
      cyc(1'b1, 16'd1, 1'b1);
      np = 0; k = 0;
      while (np < 6 && k < 100) begin
         cyc(1'b1, 16'd1, 1'b1);
         k++;
         if (upd) np++;
      end
      check("dis_reach7_cycle", k, 42);
      repeat (7) cyc(1'b1, 16'd1, 1'b1);
      check("dis_pre_jmp", jmp, 7);
      cyc(1'b0, 16'd1, 1'b1);
      check("dis_jmp", jmp, 1);
      check("dis_upd", upd, 1);
      check("dis_dir", dir, 1);
      cyc(1'b0, 16'd1, 1'b1);
      check("dis_idle_jmp", jmp, 1);
      check("dis_idle_upd", upd, 0);

      // asynchronous reset between clock edges while hold is running
      do_reset();
      cyc(1'b1, 16'd2, 1'b1);
      cyc(1'b1, 16'd2, 1'b1);
      cyc(1'b1, 16'd2, 1'b1);
      cyc(1'b1, 16'd2, 1'b0);
      check("ar_pre_jmp", jmp, 2);
      check("ar_pre_upd", upd, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_jmp", jmp, 1);
      check("ar_upd", upd, 0);
      check("ar_dir", dir, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_upd = 0;
      cyc(1'b1, 16'd3, 1'b0);
      if (upd) n_upd++;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 16'd3, 1'b1);
         if (upd) n_upd++;
         if (i < 2) begin
            cyc(1'b1, 16'd3, 1'b0);
            if (upd) n_upd++;
         end
      end
      check("ar_no_early_upd", n_upd, 0);
      check("ar_jmp_before", jmp, 1);
      cyc(1'b1, 16'd3, 1'b0);
      check("ar_first_upd", upd, 1);
      check("ar_first_jmp", jmp, 2);

      // count reaches 5 at rate 8, then rate drops to 3
      do_reset();
      cyc(1'b1, 16'd8, 1'b0);
      n_upd = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 16'd8, 1'b1);
         if (upd) n_upd++;
         cyc(1'b1, 16'd8, 1'b0);
         if (upd) n_upd++;
      end
      check("drop_no_upd", n_upd, 0);
      cyc(1'b1, 16'd3, 1'b1);
      check("drop_req_upd", upd, 0);
      cyc(1'b1, 16'd3, 1'b0);
      check("drop_step_upd", upd, 1);
      check("drop_step_jmp", jmp, 2);

      check("fixed_bad_cycles", f_bad, 0);
      check("fixed_jmp", jmp_f, 5);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
